// File: rtl/addsub_res_station_pkg.sv
// Shared constants for the Tomasulo core: ALU opcodes, tag ranges per station
// and the per-entry state encoding of the add/sub reservation station.
package addsub_res_station_pkg;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam int TAG_NONE = 0;

  // Tag ranges of the three stations must never overlap (and never include 0)
  localparam int TAG_BASE_ADDSUB = 1;
  localparam int TAG_BASE_MULT   = 4;
  localparam int TAG_BASE_DIV    = 7;

  localparam int ADDSUB_ALU = 0;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_EXEC  = 2'd3
  } entry_state_t;

endpackage

// File: rtl/addsub_res_station_rs_entry.sv
// One reservation-station entry: state register, operand capture with issue-time
// CDB bypass, CDB snoop while waiting, and release on its own tag's broadcast.
module rs_entry
  import addsub_res_station_pkg::*;
#(
  parameter int              DATA_W = 32,
  parameter int              TAG_W  = 4,
  parameter logic [TAG_W-1:0] MY_TAG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc,
  input  logic              dispatch,
  input  logic [1:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              free,
  output logic              ready,
  output logic [1:0]        op,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk
);

  entry_state_t     state;
  logic [TAG_W-1:0] qj, qk;

  logic             cdb_live;
  logic             byp_j, byp_k, snoop_j, snoop_k;
  logic [TAG_W-1:0] new_qj, new_qk;

  // Tag 0 on the bus means "nothing"; it must never match a cleared q
  assign cdb_live = cdb_valid && (cdb_tag != TAG_W'(TAG_NONE));
  assign byp_j    = cdb_live && (issue_qj == cdb_tag);
  assign byp_k    = cdb_live && (issue_qk == cdb_tag);
  assign snoop_j  = cdb_live && (qj == cdb_tag);
  assign snoop_k  = cdb_live && (qk == cdb_tag);
  assign new_qj   = byp_j ? '0 : issue_qj;
  assign new_qk   = byp_k ? '0 : issue_qk;

  assign free  = (state == ST_FREE);
  assign ready = (state == ST_READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FREE;
      op    <= '0;
      vj    <= '0;
      vk    <= '0;
      qj    <= '0;
      qk    <= '0;
    end else begin
      case (state)
        ST_FREE: begin
          if (alloc) begin
            op    <= issue_op;
            vj    <= byp_j ? cdb_data : issue_vj;
            vk    <= byp_k ? cdb_data : issue_vk;
            qj    <= new_qj;
            qk    <= new_qk;
            state <= ((new_qj == '0) && (new_qk == '0)) ? ST_READY : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (snoop_j) begin
            vj <= cdb_data;
            qj <= '0;
          end
          if (snoop_k) begin
            vk <= cdb_data;
            qk <= '0;
          end
          if (((qj == '0) || snoop_j) && ((qk == '0) || snoop_k))
            state <= ST_READY;
        end
        ST_READY: begin
          if (dispatch)
            state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (cdb_live && (cdb_tag == MY_TAG))
            state <= ST_FREE;
        end
        default: state <= ST_FREE;
      endcase
    end
  end

endmodule

// File: rtl/addsub_res_station.sv
// Add/sub/logic reservation station: free-slot and ready-slot priority encoders
// around a row of rs_entry instances, plus the dispatch payload mux.
module addsub_res_station
  import addsub_res_station_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int ENTRIES  = 3,
  parameter int TAG_BASE = TAG_BASE_ADDSUB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_en,
  input  logic [1:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic [TAG_W-1:0]  issue_tag,
  output logic              full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [1:0]        disp_op,
  output logic [DATA_W-1:0] disp_a,
  output logic [DATA_W-1:0] disp_b,
  output logic [TAG_W-1:0]  disp_tag
);

  logic [ENTRIES-1:0] free, ready, alloc, dispatch;
  logic [ENTRIES-1:0] first_free, first_ready;
  logic [1:0]         op [ENTRIES];
  logic [DATA_W-1:0]  vj [ENTRIES];
  logic [DATA_W-1:0]  vk [ENTRIES];

  // Both encoders look only at registered entry state, so a slot released this
  // edge is not reusable until the next cycle and issue never reaches dispatch.
  always_comb begin
    first_free = '0;
    issue_tag  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (free[i]) begin
        first_free    = '0;
        first_free[i] = 1'b1;
        issue_tag     = TAG_W'(TAG_BASE + i);
      end
    end
  end

  always_comb begin
    first_ready = '0;
    disp_op     = '0;
    disp_a      = '0;
    disp_b      = '0;
    disp_tag    = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready[i]) begin
        first_ready    = '0;
        first_ready[i] = 1'b1;
        disp_op        = op[i];
        disp_a         = vj[i];
        disp_b         = vk[i];
        disp_tag       = TAG_W'(TAG_BASE + i);
      end
    end
  end

  assign full       = ~|free;
  assign disp_valid = |ready;
  assign alloc      = {ENTRIES{issue_en & ~full}} & first_free;
  assign dispatch   = {ENTRIES{disp_ready}} & first_ready;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    rs_entry #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .MY_TAG (TAG_W'(TAG_BASE + gi))
    ) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .alloc     (alloc[gi]),
      .dispatch  (dispatch[gi]),
      .issue_op  (issue_op),
      .issue_vj  (issue_vj),
      .issue_vk  (issue_vk),
      .issue_qj  (issue_qj),
      .issue_qk  (issue_qk),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .free      (free[gi]),
      .ready     (ready[gi]),
      .op        (op[gi]),
      .vj        (vj[gi]),
      .vk        (vk[gi])
    );
  end

endmodule

// File: tb/tb_addsub_res_station.sv
// Bench for addsub_res_station: vector table, directed corner sequences and a
// randomized run against an array-based model of the station's rules.
module tb_addsub_res_station;

  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int ENTRIES = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_en;
  logic [1:0]        issue_op;
  logic [DATA_W-1:0] issue_vj, issue_vk;
  logic [TAG_W-1:0]  issue_qj, issue_qk;
  logic [TAG_W-1:0]  issue_tag;
  logic              full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              disp_valid, disp_ready;
  logic [1:0]        disp_op;
  logic [DATA_W-1:0] disp_a, disp_b;
  logic [TAG_W-1:0]  disp_tag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addsub_res_station #(.DATA_W(DATA_W), .TAG_W(TAG_W), .ENTRIES(ENTRIES), .TAG_BASE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_en(issue_en), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_tag(issue_tag), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_a(disp_a), .disp_b(disp_b), .disp_tag(disp_tag)
  );

  typedef struct {
    logic        en;
    logic [1:0]  op;
    logic [31:0] vj, vk;
    logic [3:0]  qj, qk;
    logic        cv;
    logic [3:0]  ct;
    logic [31:0] cd;
    logic        rdy;
    logic        x_full;
    logic [3:0]  x_itag;
    logic        x_dv;
    logic [31:0] x_a, x_b;
    logic [3:0]  x_tag;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic en, input logic [1:0] op, input logic [31:0] vj, vk,
                              input logic [3:0] qj, qk, input logic cv, input logic [3:0] ct,
                              input logic [31:0] cd, input logic rdy, input logic x_full,
                              input logic [3:0] x_itag, input logic x_dv,
                              input logic [31:0] x_a, x_b, input logic [3:0] x_tag);
    vec_t v;
    v.en = en; v.op = op; v.vj = vj; v.vk = vk; v.qj = qj; v.qk = qk;
    v.cv = cv; v.ct = ct; v.cd = cd; v.rdy = rdy;
    v.x_full = x_full; v.x_itag = x_itag; v.x_dv = x_dv;
    v.x_a = x_a; v.x_b = x_b; v.x_tag = x_tag;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    issue_en = 1'b0; issue_op = '0; issue_vj = '0; issue_vk = '0;
    issue_qj = '0; issue_qk = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic drive_issue(input logic [1:0] op, input logic [31:0] vj, vk,
                             input logic [3:0] qj, qk);
    issue_en = 1'b1; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj = qj; issue_qk = qk;
  endtask

  task automatic drive_cdb(input logic [3:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
  endtask

  // Reference model: 0=free 1=wait 2=ready 3=exec; entry i owns tag i+1
  int          m_st [ENTRIES];
  logic [1:0]  m_op [ENTRIES];
  logic [31:0] m_vj [ENTRIES];
  logic [31:0] m_vk [ENTRIES];
  logic [3:0]  m_qj [ENTRIES];
  logic [3:0]  m_qk [ENTRIES];

  function automatic int first_in_state(input int st);
    for (int i = 0; i < ENTRIES; i++)
      if (m_st[i] == st) return i;
    return -1;
  endfunction

  task automatic model_update();
    int ff, rd;
    bit live;
    ff = first_in_state(0);
    rd = first_in_state(2);
    live = cdb_valid && (cdb_tag != 0);
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_st[i] == 1) begin
        if (live && m_qj[i] == cdb_tag) begin m_vj[i] = cdb_data; m_qj[i] = 0; end
        if (live && m_qk[i] == cdb_tag) begin m_vk[i] = cdb_data; m_qk[i] = 0; end
        if (m_qj[i] == 0 && m_qk[i] == 0) m_st[i] = 2;
      end else if (m_st[i] == 2) begin
        if (i == rd && disp_ready) m_st[i] = 3;
      end else if (m_st[i] == 3) begin
        if (live && cdb_tag == 4'(i + 1)) m_st[i] = 0;
      end
    end
    if (issue_en && ff >= 0) begin
      m_op[ff] = issue_op;
      m_vj[ff] = (live && issue_qj == cdb_tag) ? cdb_data : issue_vj;
      m_vk[ff] = (live && issue_qk == cdb_tag) ? cdb_data : issue_vk;
      m_qj[ff] = (live && issue_qj == cdb_tag) ? 4'd0 : issue_qj;
      m_qk[ff] = (live && issue_qk == cdb_tag) ? 4'd0 : issue_qk;
      m_st[ff] = (m_qj[ff] == 0 && m_qk[ff] == 0) ? 2 : 1;
    end
  endtask

  initial begin
    logic [3:0] pool [6];
    int ff, rd;
    pool[0] = 0; pool[1] = 1; pool[2] = 2; pool[3] = 3; pool[4] = 6; pool[5] = 9;

    vecs[0]  = mk(1, 0, 5, 7, 0, 0, 0, 0, 0,     1, 0, 1, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0, 2, 1, 5, 7, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 'h99,  1, 0, 2, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 0, 3, 9, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 2, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 9, 'h20,  0, 0, 2, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 2, 1, 'h20, 3, 1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0, 2, 1, 'h20, 3, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0,     0, 0, 2, 0, 0, 0, 0);
    vecs[10] = mk(1, 0, 4, 0, 0, 9, 1, 9, 'h33,  0, 0, 1, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 2, 1, 4, 'h33, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0, 2, 1, 4, 'h33, 1);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0,     0, 0, 2, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0);

    rst_n = 1'b0;
    drive_idle();
    disp_ready = 1'b0;
    #12;
    chk("rst_full", full, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_op", disp_op, 0);
    chk("rst_disp_a", disp_a, 0);
    chk("rst_disp_b", disp_b, 0);
    chk("rst_disp_tag", disp_tag, 0);
    chk("rst_issue_tag", issue_tag, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      issue_en = vecs[i].en; issue_op = vecs[i].op;
      issue_vj = vecs[i].vj; issue_vk = vecs[i].vk;
      issue_qj = vecs[i].qj; issue_qk = vecs[i].qk;
      cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ct; cdb_data = vecs[i].cd;
      disp_ready = vecs[i].rdy;
      chk($sformatf("vec%0d_full", i), full, vecs[i].x_full);
      chk($sformatf("vec%0d_issue_tag", i), issue_tag, vecs[i].x_itag);
      chk($sformatf("vec%0d_disp_valid", i), disp_valid, vecs[i].x_dv);
      if (vecs[i].x_dv) begin
        chk($sformatf("vec%0d_disp_a", i), disp_a, vecs[i].x_a);
        chk($sformatf("vec%0d_disp_b", i), disp_b, vecs[i].x_b);
        chk($sformatf("vec%0d_disp_tag", i), disp_tag, vecs[i].x_tag);
      end
      step();
    end
    drive_idle();

    // Fill all three entries waiting on tag 6, then wake them with one broadcast
    disp_ready = 1'b0;
    drive_issue(0, 10, 11, 6, 0); chk("fill_tag1", issue_tag, 1); step();
    drive_issue(1, 20, 21, 6, 0); chk("fill_tag2", issue_tag, 2); step();
    drive_issue(2, 30, 31, 6, 0); chk("fill_tag3", issue_tag, 3); step();
    chk("fill_full", full, 1);
    chk("fill_issue_tag0", issue_tag, 0);
    drive_issue(3, 40, 41, 0, 0); step();
    drive_idle();
    chk("fourth_ignored_full", full, 1);
    chk("fourth_ignored_dv", disp_valid, 0);
    drive_cdb(6, 'h66); disp_ready = 1'b1; step();
    drive_idle();
    chk("wake_dv", disp_valid, 1);
    chk("order1_tag", disp_tag, 1);
    chk("order1_a", disp_a, 'h66);
    chk("order1_b", disp_b, 11);
    step();
    chk("order2_tag", disp_tag, 2);
    chk("order2_b", disp_b, 21);
    step();
    chk("order3_tag", disp_tag, 3);
    chk("order3_b", disp_b, 31);
    step();
    chk("all_exec_dv", disp_valid, 0);
    chk("all_exec_full", full, 1);

    // Release tag 2 while an issue is attempted against the full station
    disp_ready = 1'b0;
    drive_cdb(2, 0);
    drive_issue(0, 1, 2, 0, 0);
    chk("rel_full_before", full, 1);
    step();
    cdb_valid = 1'b0; cdb_tag = 0;
    chk("rel_full_after", full, 0);
    chk("rel_issue_tag", issue_tag, 2);
    chk("rel_issue_ignored_dv", disp_valid, 0);
    step();
    issue_en = 1'b0;
    chk("reissue_full", full, 1);
    chk("reissue_dv", disp_valid, 1);
    chk("reissue_tag", disp_tag, 2);
    chk("reissue_a", disp_a, 1);
    chk("reissue_b", disp_b, 2);

    // Leave entries in EXEC/READY/WAIT, then reset asynchronously mid-cycle
    drive_cdb(3, 0); step();
    drive_idle();
    chk("pre_rst_issue_tag", issue_tag, 3);
    drive_issue(0, 0, 0, 5, 0); step();
    drive_idle();
    chk("pre_rst_full", full, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_full", full, 0);
    chk("async_rst_dv", disp_valid, 0);
    chk("async_rst_issue_tag", issue_tag, 1);
    chk("async_rst_disp_a", disp_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_cdb(5, 'h55); step();
    drive_cdb(1, 'h11); step();
    drive_idle();
    chk("old_tag_dv", disp_valid, 0);
    chk("old_tag_full", full, 0);
    chk("old_tag_issue_tag", issue_tag, 1);

    // Randomized run from the clean post-reset state
    for (int i = 0; i < ENTRIES; i++) begin
      m_st[i] = 0; m_op[i] = 0; m_vj[i] = 0; m_vk[i] = 0; m_qj[i] = 0; m_qk[i] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      issue_en = $urandom_range(0, 1) == 1;
      issue_op = 2'($urandom_range(0, 3));
      issue_vj = $urandom; issue_vk = $urandom;
      issue_qj = pool[$urandom_range(0, 5)];
      issue_qk = ($urandom_range(0, 1) == 1) ? 4'd0 : pool[$urandom_range(0, 5)];
      cdb_valid = $urandom_range(0, 2) != 0;
      cdb_tag = pool[$urandom_range(0, 5)];
      cdb_data = $urandom;
      disp_ready = $urandom_range(0, 3) != 0;
      ff = first_in_state(0);
      rd = first_in_state(2);
      chk("rnd_full", full, ff < 0);
      chk("rnd_issue_tag", issue_tag, (ff < 0) ? 0 : ff + 1);
      chk("rnd_disp_valid", disp_valid, rd >= 0);
      if (rd >= 0) begin
        chk("rnd_disp_tag", disp_tag, rd + 1);
        chk("rnd_disp_op", disp_op, m_op[rd]);
        chk("rnd_disp_a", disp_a, m_vj[rd]);
        chk("rnd_disp_b", disp_b, m_vk[rd]);
      end
      model_update();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_res_station.md
# addsub_res_station

Three-entry reservation station for the add/sub/logic functional unit of the Tomasulo core. It sits directly downstream of the decode/control unit, which supplies the issue enable (`ResStationEN[0]`), the 2-bit ALU opcode and the `isFull[addsubALU]` feedback. It holds issued instructions, snoops the common data bus (CDB) for missing operands and dispatches ready instructions to the add/sub ALU. Each entry is released when its own result is broadcast.

## Interface
Parameters:
- `DATA_W`, 32, operand width
- `TAG_W`, 4, tag width; tag 0 means "no dependency / value valid"
- `ENTRIES`, 3, station depth
- `TAG_BASE`, 1, tag of entry 0; entry i owns tag `TAG_BASE+i` (never 0)

Ports:
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `issue_en` in 1 — issue request (CU `ResStationEN[0]`)
- `issue_op` in 2 — ALU opcode (`ALUAdd/ALUSub/ALUAnd/ALUOr`)
- `issue_vj`, `issue_vk` in DATA_W — operand values, valid when matching q is 0
- `issue_qj`, `issue_qk` in TAG_W — producer tags, 0 = ready
- `issue_tag` out TAG_W — tag allocated to the current issue; 0 when full
- `full` out 1 — all entries busy; drives CU `isFull[addsubALU]`
- `cdb_valid` in 1, `cdb_tag` in TAG_W, `cdb_data` in DATA_W — result broadcast
- `disp_valid` out 1, `disp_ready` in 1 — dispatch handshake to ALU
- `disp_op` out 2, `disp_a` out DATA_W, `disp_b` out DATA_W, `disp_tag` out TAG_W — dispatched instruction

## Operation
- Per-entry state: FREE, WAIT (one or more q nonzero), READY (qj=qk=0, not yet dispatched), EXEC (dispatched, awaiting own broadcast).
- Issue: when `issue_en && !full`, the lowest-index FREE entry is written at the clock edge. Its state becomes READY if both effective q are 0, else WAIT. `issue_en` while `full` is ignored; the CU is responsible for stalling.
- Issue-time bypass: if `cdb_valid` and `cdb_tag` equals a nonzero `issue_qj`/`issue_qk` in the same cycle, that operand is captured from `cdb_data` and its q is stored as 0.
- CDB snoop: every WAIT entry with `qj==cdb_tag` (or `qk`, tag nonzero) latches `cdb_data` into vj/vk and clears that q. WAIT becomes READY when both are cleared.
- Dispatch: `disp_valid` = any READY entry. The payload comes from the lowest-index READY entry. On `disp_valid && disp_ready` that entry becomes EXEC. The ALU samples only on the handshake cycle, so the payload may change between non-accepted cycles.
- Release: an EXEC entry whose own tag equals `cdb_tag` with `cdb_valid` becomes FREE.
- `full` = no FREE entry, computed from registered state. A release and an issue in the same cycle therefore cannot use the released slot.
- `issue_tag` = tag of the lowest FREE entry (combinational), or 0.

## Timing
- Reset (async assert, sync release): all entries FREE, all q/v cleared. Outputs: `full=0`, `disp_valid=0`, `disp_op=0`, `disp_a=0`, `disp_b=0`, `disp_tag=0`, `issue_tag=TAG_BASE`.
- Reset mid-operation discards all entries immediately, with no further dispatch.
- Issue at edge N gives `disp_valid` at N+1 at the earliest (no combinational issue→dispatch path).
- CDB capture at edge N lets the entry dispatch at N+1 at the earliest.
- Release at edge N makes `full` deassert in the cycle after N.
- Simultaneous events:
  - CDB broadcast releases entry A, wakes entry B and bypasses into an issuing instruction, all in one edge.
  - Dispatch and snoop never target the same entry, because READY entries do not snoop.
- A broadcast with a tag matching nothing has no effect.
- A tag-0 broadcast is ignored.

## Structure
- Shared `head.v` defines:
  - ALU opcodes
  - `TAG_NONE` (0)
  - per-station `TAG_BASE` values (add/sub, mult, div ranges must not overlap)
  - `addsubALU` index
- Sub-module `rs_entry`: one entry's state register, operand capture and CDB compare.
- The top level holds the free/ready priority encoders and the dispatch mux.

## Test plan
- Reset, then issue ADD vj=5 vk=7 q=0/0 → `issue_tag`=1 on the issue cycle; next cycle `disp_valid=1`, `disp_a=5`, `disp_b=7`, `disp_tag=1`. With `disp_ready=1`, then a CDB tag 1 broadcast → entry FREE, `full=0`.
- Issue SUB with qj=9 and `disp_ready=0`; CDB tag 9 data 0x20 two cycles later → `disp_valid` rises the cycle after capture with `disp_a=0x20`.
- Issue with qk=9 in the same cycle as CDB tag 9 data 0x33 → entry READY immediately, `disp_b=0x33`.
- Issue three instructions with all q=6 → `full=1`, `issue_tag=0`. A fourth `issue_en` is ignored. CDB tag 6 → all READY, dispatched in order tags 1, 2, 3 with `disp_ready` held high.
- EXEC entry tag 2 released and a new issue in the same cycle while full → issue ignored; the next cycle the issue succeeds with `issue_tag=2`.
- Assert `rst_n=0` mid-cycle with entries in WAIT/EXEC → `full=0`, `disp_valid=0` immediately; a later CDB with an old tag has no effect.
